// File: rtl/fetch_queue.sv
// fetch_queue: instruction-fetch front end with a DEPTH-entry prefetch FIFO.
//
// The block issues sequential word fetches to a synchronous instruction memory.
// It buffers each returned instruction together with its PC, and it presents
// the head entry to the IF/OF register through a valid/ready handshake. A
// redirect flushes the buffer, drops any in-flight fetch and reloads the PC.
//
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   stop              suppresses new fetch issue; buffered entries still drain
//   redirect          flush + restart at redirect_pc (bits [1:0] ignored)
//   IMclka/IMaddra    instruction-memory clock and word address
//   IMdouta           memory data, valid the cycle after the address
//   inst_valid/ready  head-of-queue handshake
//   inst/inst_pc      head instruction and PC (0 when empty)
//   count             current occupancy
module fetch_queue #(
  parameter int              XLEN     = 32,
  parameter int              ADDR_W   = 7,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     stop,
  input  logic                     redirect,
  input  logic [XLEN-1:0]          redirect_pc,
  output logic                     IMclka,
  output logic [ADDR_W-1:0]        IMaddra,
  input  logic [XLEN-1:0]          IMdouta,
  output logic                     inst_valid,
  input  logic                     inst_ready,
  output logic [XLEN-1:0]          inst,
  output logic [XLEN-1:0]          inst_pc,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0]   CAP  = (CW+1)'(DEPTH);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } entry_t;

  entry_t          fifo_q [DEPTH];
  logic [PW:0]     wptr, rptr;      // extra wrap bit distinguishes full from empty
  logic            inflight;
  logic [XLEN-1:0] fetch_pc, pend_pc;
  logic [CW:0]     reserved;
  logic            issue, enq, deq;
  entry_t          head;
  logic            unused_pc_lsb;

  assign unused_pc_lsb = ^redirect_pc[1:0];

  assign count      = wptr - rptr;
  assign inst_valid = (count != '0);
  assign head       = fifo_q[rptr[PW-1:0]];
  assign inst       = inst_valid ? head.inst : '0;
  assign inst_pc    = inst_valid ? head.pc   : '0;

  assign IMclka  = clk;
  assign IMaddra = fetch_pc[ADDR_W+1:2];

  // An in-flight fetch already owns a slot, so the FIFO can never overflow.
  assign reserved = {1'b0, count} + (CW+1)'(inflight);
  assign issue    = !rst && !stop && !redirect && (reserved < CAP);
  assign enq      = inflight && !redirect;
  assign deq      = inst_valid && inst_ready && !redirect;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr     <= '0;
      rptr     <= '0;
      inflight <= 1'b0;
      fetch_pc <= RESET_PC;
      pend_pc  <= '0;
    end else if (redirect) begin
      wptr     <= '0;
      rptr     <= '0;
      inflight <= 1'b0;
      fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00};
    end else begin
      if (enq) wptr <= wptr + 1'b1;
      if (deq) rptr <= rptr + 1'b1;
      inflight <= issue;
      if (issue) begin
        pend_pc  <= fetch_pc;
        fetch_pc <= fetch_pc + XLEN'(4);
      end
    end
  end

  // Storage needs no reset; occupancy is tracked entirely by the pointers.
  always_ff @(posedge clk) begin
    if (enq) fifo_q[wptr[PW-1:0]] <= '{pc: pend_pc, inst: IMdouta};
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(enq && !deq && count == FULL));

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;
  localparam int XLEN = 32, ADDR_W = 7, DEPTH = 4;

  logic              clk = 1'b0;
  logic              rst, stop, redirect, inst_ready;
  logic [XLEN-1:0]   redirect_pc, IMdouta, inst, inst_pc;
  logic              IMclka, inst_valid;
  logic [ADDR_W-1:0] IMaddra;
  logic [2:0]        count;

  fetch_queue #(.XLEN(XLEN), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .RESET_PC('0)) dut (
    .clk(clk), .rst(rst), .stop(stop), .redirect(redirect), .redirect_pc(redirect_pc),
    .IMclka(IMclka), .IMaddra(IMaddra), .IMdouta(IMdouta),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc),
    .count(count));

  always #5 clk = ~clk;

  // Synchronous instruction memory: word k holds 0x1000+k.
  always @(posedge clk) IMdouta <= 32'h1000 + {25'd0, IMaddra};

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of buffered PCs plus the fetch pointer and one pending fetch.
  logic [31:0] mq[$];
  logic [31:0] m_pc, m_pend;
  bit          m_infl;
  logic        cur_s, cur_r, cur_rdy;
  logic [31:0] cur_rpc;

  function automatic logic [31:0] word_of(input logic [31:0] pc);
    return 32'h1000 + {25'd0, pc[8:2]};
  endfunction

  task automatic model_reset();
    mq.delete();
    m_pc   = 32'h0;
    m_pend = 32'h0;
    m_infl = 0;
  endtask

  task automatic model_check();
    chk("m_valid", {31'd0, inst_valid}, {31'd0, mq.size() != 0});
    chk("m_pc",    inst_pc, mq.size() != 0 ? mq[0] : 32'h0);
    chk("m_inst",  inst,    mq.size() != 0 ? word_of(mq[0]) : 32'h0);
    chk("m_count", {29'd0, count}, mq.size());
    chk("m_addr",  {25'd0, IMaddra}, {25'd0, m_pc[8:2]});
  endtask

  task automatic model_update();
    int  c;
    bit  iss;
    c   = mq.size();
    iss = !cur_s && !cur_r && (c + int'(m_infl) < DEPTH);
    if (cur_r) begin
      mq.delete();
      m_infl = 0;
      m_pc   = {cur_rpc[31:2], 2'b00};
    end else begin
      if (cur_rdy && c > 0) void'(mq.pop_front());
      if (m_infl) mq.push_back(m_pend);
      if (iss) begin
        m_pend = m_pc;
        m_pc   = m_pc + 32'd4;
      end
      m_infl = iss;
    end
  endtask

  // Called at a negedge: apply inputs and let them settle.
  task automatic drive(input logic s, input logic r, input logic [31:0] rpc, input logic rdy);
    cur_s = s; cur_r = r; cur_rpc = rpc; cur_rdy = rdy;
    stop = s; redirect = r; redirect_pc = rpc; inst_ready = rdy;
    #1;
  endtask

  task automatic advance();
    model_check();
    model_update();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic step(input logic s, input logic r, input logic [31:0] rpc, input logic rdy);
    drive(s, r, rpc, rdy);
    advance();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    stop = 0; redirect = 0; redirect_pc = 0; inst_ready = 0;
    model_reset();
    #1;
    chk("rst_count", {29'd0, count}, 32'd0);
    chk("rst_valid", {31'd0, inst_valid}, 32'd0);
    chk("rst_inst",  inst, 32'd0);
    chk("rst_pc",    inst_pc, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct {
    bit          do_rst;
    bit          rdy;
    logic [6:0]  addr;
    bit          vld;
    logic [31:0] pc;
    logic [31:0] ins;
    logic [2:0]  cnt;
  } vec_t;

  vec_t vt[$];

  initial begin
    logic [6:0]  held;
    logic [31:0] last_pc;
    bit          have_last;

    rst = 1'b1; stop = 0; redirect = 0; redirect_pc = 0; inst_ready = 0;
    model_reset();
    @(negedge clk);

    // Streaming from reset, then stall-until-full and drain.
    vt.push_back('{1, 1, 7'd0, 0, 32'd0,  32'h0,    3'd0});
    vt.push_back('{0, 1, 7'd1, 0, 32'd0,  32'h0,    3'd0});
    vt.push_back('{0, 1, 7'd2, 1, 32'd0,  32'h1000, 3'd1});
    vt.push_back('{0, 1, 7'd3, 1, 32'd4,  32'h1001, 3'd1});
    vt.push_back('{0, 1, 7'd4, 1, 32'd8,  32'h1002, 3'd1});
    vt.push_back('{1, 0, 7'd0, 0, 32'd0,  32'h0,    3'd0});
    vt.push_back('{0, 0, 7'd1, 0, 32'd0,  32'h0,    3'd0});
    vt.push_back('{0, 0, 7'd2, 1, 32'd0,  32'h1000, 3'd1});
    vt.push_back('{0, 0, 7'd3, 1, 32'd0,  32'h1000, 3'd2});
    vt.push_back('{0, 0, 7'd4, 1, 32'd0,  32'h1000, 3'd3});
    for (int i = 0; i < 5; i++) vt.push_back('{0, 0, 7'd4, 1, 32'd0, 32'h1000, 3'd4});
    vt.push_back('{0, 1, 7'd4, 1, 32'd0,  32'h1000, 3'd4});
    vt.push_back('{0, 1, 7'd4, 1, 32'd4,  32'h1001, 3'd3});
    vt.push_back('{0, 1, 7'd5, 1, 32'd8,  32'h1002, 3'd2});
    vt.push_back('{0, 1, 7'd6, 1, 32'd12, 32'h1003, 3'd2});
    vt.push_back('{0, 1, 7'd7, 1, 32'd16, 32'h1004, 3'd2});
    vt.push_back('{0, 1, 7'd8, 1, 32'd20, 32'h1005, 3'd2});

    foreach (vt[i]) begin
      if (vt[i].do_rst) do_reset();
      drive(0, 0, 32'h0, vt[i].rdy);
      chk($sformatf("vec%0d_addr", i),  {25'd0, IMaddra}, {25'd0, vt[i].addr});
      chk($sformatf("vec%0d_valid", i), {31'd0, inst_valid}, {31'd0, vt[i].vld});
      chk($sformatf("vec%0d_pc", i),    inst_pc, vt[i].pc);
      chk($sformatf("vec%0d_inst", i),  inst, vt[i].ins);
      chk($sformatf("vec%0d_count", i), {29'd0, count}, {29'd0, vt[i].cnt});
      advance();
    end

    // Redirect to 0x40 with 3 buffered entries and a fetch in flight.
    do_reset();
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0);
    chk("redir_pre_count", {29'd0, count}, 32'd3);
    step(0, 1, 32'h40, 0);
    chk("redir_count0", {29'd0, count}, 32'd0);
    step(0, 0, 0, 1);
    chk("redir_r2_valid", {31'd0, inst_valid}, 32'd0);
    step(0, 0, 0, 1);
    chk("redir_r3_valid", {31'd0, inst_valid}, 32'd1);
    chk("redir_r3_pc", inst_pc, 32'h40);
    for (int i = 0; i < 6; i++) begin
      chk("redir_no_old", {31'd0, inst_valid && inst_pc < 32'h40}, 32'd0);
      step(0, 0, 0, 1);
    end

    // stop for 5 cycles mid-stream; output PCs stay contiguous.
    have_last = 0;
    last_pc = 0;
    for (int i = 0; i < 18; i++) begin
      logic s;
      s = (i >= 4 && i < 9);
      drive(s, 0, 0, 1);
      if (i == 4) held = IMaddra;
      if (s) chk("stop_addr_held", {25'd0, IMaddra}, {25'd0, held});
      if (inst_valid) begin
        if (have_last) chk("stop_contig", inst_pc, last_pc + 32'd4);
        last_pc = inst_pc;
        have_last = 1;
      end
      advance();
    end

    // Redirect while stopped to 0x1FE, then resume: address wraps 0x7F -> 0x00.
    step(1, 1, 32'h1FE, 1);
    drive(1, 0, 0, 1);
    chk("wrap_addr_stop", {25'd0, IMaddra}, 32'h7F);
    advance();
    drive(0, 0, 0, 1);
    chk("wrap_addr_7f", {25'd0, IMaddra}, 32'h7F);
    advance();
    drive(0, 0, 0, 1);
    chk("wrap_addr_00", {25'd0, IMaddra}, 32'h00);
    advance();
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1);

    // Asynchronous reset mid-cycle with 3 entries buffered.
    do_reset();
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0);
    chk("arst_pre_count", {29'd0, count}, 32'd3);
    #2 rst = 1'b1;
    #1;
    chk("arst_count", {29'd0, count}, 32'd0);
    chk("arst_valid", {31'd0, inst_valid}, 32'd0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    drive(0, 0, 0, 1);
    chk("arst_restart_addr", {25'd0, IMaddra}, 32'd0);
    advance();
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1);

    // Randomised traffic against the model, including PCs near the 2^32 wrap.
    for (int i = 0; i < 400; i++) begin
      logic        s, r, rdy;
      logic [31:0] rpc;
      s   = ($urandom_range(0, 99) < 20);
      r   = ($urandom_range(0, 99) < 5);
      rdy = ($urandom_range(0, 99) < 65);
      rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 + {28'd0, 4'($urandom)}) : $urandom;
      step(s, r, rpc, rdy);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
Parametrised instruction-fetch front end with a prefetch buffer. It issues sequential word fetches to the synchronous instruction memory and buffers returned instructions with their PCs in a DEPTH-entry FIFO. It presents them to the IF/OF pipeline register through a valid/ready handshake. A single-cycle redirect from the branch unit flushes the buffer and drops any in-flight fetch. It replaces the PC-only stall of the current IF stage.

Parameters:
XLEN, 32, instruction and PC width
ADDR_W, 7, instruction-memory word-address width
DEPTH, 4, FIFO entries; power of two, >= 2
RESET_PC, 0, byte PC fetched first after reset

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
stop  in  1  halt new fetch issue; buffered entries still drain
redirect  in  1  branch taken; flush and restart at redirect_pc
redirect_pc  in  XLEN  new byte PC; bits [1:0] ignored (forced 0)
IMclka  out  1  instruction-memory clock, equal to clk
IMaddra  out  ADDR_W  word address, fetch_pc[ADDR_W+1:2]
IMdouta  in  XLEN  instruction data; valid the cycle after its address is issued
inst_valid  out  1  head entry valid
inst_ready  in  1  consumer accepts head this cycle
inst  out  XLEN  head instruction; 0 when inst_valid=0
inst_pc  out  XLEN  head PC; 0 when inst_valid=0
count  out  clog2(DEPTH)+1  current occupancy

Behaviour:
- Reset (async, immediate):
  - count=0, inst_valid=0, inst=0, inst_pc=0.
  - fetch_pc=RESET_PC; in-flight flag cleared.
  - Read/write pointers are 0 and are clog2(DEPTH)+1 bits with wrap bit.
- Issue condition, evaluated each cycle: issue = !rst & !stop & !redirect & (count + inflight < DEPTH).
  - On issue: IMaddra shows fetch_pc's word address.
  - At the clock edge: inflight<=1, pend_pc<=fetch_pc, fetch_pc<=fetch_pc+4 (mod 2^XLEN).
  - With no issue, inflight<=0 and fetch_pc holds.
  - IMaddra always shows fetch_pc[ADDR_W+1:2].
- Response:
  - In the cycle after an issue, IMdouta and pend_pc are written at the tail at the edge.
  - This applies only if no redirect is asserted in that cycle.
- Latency: address issued in cycle N, enqueued at the end of N+1, inst_valid=1 in N+2.
- Throughput: one instruction per cycle sustained when inst_ready=1.
- Dequeue: inst_valid & inst_ready pops the head at the edge.
  - inst_ready with inst_valid=0 has no effect.
- Simultaneous enqueue and dequeue: count unchanged, both pointers advance.
- Overflow is impossible by reservation: inflight counts against capacity.
  - An assertion flags enqueue while count==DEPTH.
- Full: count==DEPTH means no issue; issue resumes the cycle after a pop frees a slot.
- Empty: inst_valid=0, inst and inst_pc forced to 0.
- Redirect (highest priority), at the edge:
  - Pointers reset; count=0.
  - The pending response is discarded (inflight<=0).
  - fetch_pc<={redirect_pc[XLEN-1:2],2'b00}.
  - No issue occurs in the redirect cycle.
  - A pop in the same cycle is ignored (the entry is flushed).
  - First new issue is in redirect+1; the target appears on inst_valid in redirect+3.
- Redirect while stop=1: flush and PC load still happen; issue waits for stop=0.
- stop deasserted mid-stream:
  - The in-flight response is still enqueued.
  - fetch_pc resumes exactly where it stopped; no skipped or duplicated PCs.
- Reset mid-operation: all state returns to reset values; the pending IMdouta is never enqueued.
- PC wrap: fetch_pc wraps modulo 2^XLEN. IMaddra truncates to ADDR_W bits, so the memory address wraps modulo 2^ADDR_W words.

Test Plan:
- Reset release, IM word k = 0x1000+k, RESET_PC=0, inst_ready=1 -> IMaddra 0,1,2,… each cycle. inst_valid rises 2 cycles after release; inst_pc=0,4,8 with inst=0x1000,0x1001,0x1002 on consecutive cycles; count stays <=2.
- inst_ready=0 for 10 cycles, DEPTH=4 -> count saturates at 4 and IMaddra freezes at 4. Raising inst_ready delivers PCs 0,4,8,12 then 16 with no gap or duplicate.
- Redirect to 0x40 while the queue holds 3 entries and a fetch is in flight -> count=0 next cycle. The next valid inst_pc is 0x40 exactly 3 cycles after redirect; no old PC ever appears afterwards.
- stop=1 for 5 cycles mid-stream, then 0 -> the in-flight entry is enqueued and no address is issued during stop. The output PC sequence stays strictly +4 contiguous.
- Redirect to 0x1FE with stop=1, then stop=0 -> fetch resumes at 0x1FC (IMaddra=0x7F), next at 0x200 with IMaddra wrapping to 0x00.
- Async rst pulse mid-cycle with count=3 -> inst_valid and count drop to 0 immediately. After release, the fetch sequence restarts at RESET_PC.
